// File: rtl/linear_base_learner.sv
// Streaming linear classifier: accumulates sum(f[i]*w[i]), subtracts bias, and
// compares against thred. Define PULSE_READY_EN for a one-cycle ready with no HOLD state.
module linear_base_learner #(
  parameter int NFEAT = 4,
  parameter int FW    = 8,
  parameter int WW    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                feat_valid,
  input  logic [FW-1:0]       feat_data,
  output logic                feat_ready,
  input  logic [NFEAT*WW-1:0] weights,
  input  logic [WW-1:0]       bias,
  input  logic [WW-1:0]       thred,
  input  logic                ack,
  output logic                ready,
  output logic [1:0]          predict
);

  localparam int AW = FW + WW + $clog2(NFEAT) + 1;
  localparam int IW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam logic [IW-1:0] LAST = IW'(NFEAT - 1);

  typedef enum logic [1:0] {IDLE, ACC, CMP, HOLD} state_t;

  state_t               state;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] res;
  logic [IW-1:0]        idx;
  logic [WW-1:0]        w_sel;
  logic                 accept;

  assign feat_ready = !rst && (state == IDLE || state == ACC);
  assign accept     = feat_valid && feat_ready;

  // idx is 0 whenever a sample starts, so IDLE naturally picks w[0].
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NFEAT; i++) begin
      if (IW'(i) == idx) w_sel = weights[i*WW +: WW];
    end
  end

  // Size casts of signed operands sign-extend, so the arithmetic is exact at AW bits.
  assign prod = AW'($signed(feat_data)) * AW'($signed(w_sel));
  assign res  = acc - AW'($signed(bias));

  // NOTE: every register here is state, so it is assigned with <= only; blocking
  // assignments would let later statements see the new value within the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      idx     <= '0;
      ready   <= 1'b0;
      predict <= 2'b00;
    end else begin
      case (state)
        IDLE, ACC: begin
          ready <= 1'b0;
          if (accept) begin
            acc   <= (state == IDLE) ? prod : acc + prod;
            idx   <= (idx == LAST) ? '0 : idx + IW'(1);
            state <= (idx == LAST) ? CMP : ACC;
          end
        end
        CMP: begin
          predict <= (res > AW'($signed(thred))) ? 2'b01 : 2'b11;
          ready   <= 1'b1;
`ifdef PULSE_READY_EN
          acc     <= '0;
          state   <= IDLE;
`else
          state   <= HOLD;
`endif
        end
        HOLD: begin
          if (ack) begin
            ready <= 1'b0;
            acc   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_base_learner.sv
// Self-checking bench for linear_base_learner: directed cases with literal
// expectations plus randomized traffic compared every cycle against a sample-level model.
module tb_linear_base_learner;

  localparam int NFEAT = 4;
  localparam int FW    = 8;
  localparam int WW    = 10;

  typedef logic [FW-1:0] sample_t [NFEAT];

  logic                clk;
  logic                rst;
  logic                feat_valid;
  logic [FW-1:0]       feat_data;
  logic                feat_ready;
  logic [NFEAT*WW-1:0] weights;
  logic [WW-1:0]       bias;
  logic [WW-1:0]       thred;
  logic                ack;
  logic                ready;
  logic [1:0]          predict;

  int n_checks = 0;
  int n_fail   = 0;

  linear_base_learner #(.NFEAT(NFEAT), .FW(FW), .WW(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .feat_valid (feat_valid),
    .feat_data  (feat_data),
    .feat_ready (feat_ready),
    .weights    (weights),
    .bias       (bias),
    .thred      (thred),
    .ack        (ack),
    .ready      (ready),
    .predict    (predict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample-level model: collect features, compute the dot product when the
  // sample is complete, decide one edge later, hold until acknowledged.
  logic [FW-1:0] q[$];
  bit            m_pending;
  bit            m_hold;
  logic [1:0]    m_pred;
  int            m_sum;
  int            m_res;
  int            n_done;

  function automatic int w_of(input int i);
    return int'($signed(weights[i*WW +: WW]));
  endfunction

  initial begin
    m_pending = 0; m_hold = 0; m_pred = 2'b00; m_sum = 0; m_res = 0; n_done = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_pending = 0;
        m_hold    = 0;
        m_pred    = 2'b00;
      end else if (m_hold) begin
        if (ack) m_hold = 0;
      end else if (m_pending) begin
        m_res     = m_sum - int'($signed(bias));
        m_pred    = (m_res > int'($signed(thred))) ? 2'b01 : 2'b11;
        m_pending = 0;
        m_hold    = 1;
        n_done++;
      end else if (feat_valid) begin
        q.push_back(feat_data);
        if (q.size() == NFEAT) begin
          m_sum = 0;
          for (int i = 0; i < NFEAT; i++) m_sum += int'($signed(q[i])) * w_of(i);
          q.delete();
          m_pending = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(ready), 32'(m_hold));
    check("predict", 32'(predict), 32'(m_pred));
    check("feat_ready", 32'(feat_ready), 32'(!rst && !m_pending && !m_hold));
  end

  task automatic set_w(input int a, input int b, input int c, input int d);
    weights = {WW'(d), WW'(c), WW'(b), WW'(a)};
  endtask

  task automatic wait_fr(input string name);
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = feat_ready;
    end
    if (!ok) check({name, "_fr_timeout"}, 0, 1);
  endtask

  task automatic beat(input string name, input logic [FW-1:0] f);
    feat_data  = f;
    feat_valid = 1'b1;
    wait_fr(name);
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input string name, input sample_t s, input int gap);
    for (int i = 0; i < NFEAT; i++) begin
      beat(name, s[i]);
      if (gap > 0) begin
        feat_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    feat_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = ready;
    end
    if (!ok) check({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; feat_valid = 1'b0; feat_data = '0; ack = 1'b0;
    set_w(1, 2, 3, 4); bias = '0; thred = WW'(5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready), 0);
    check("reset_predict", 32'(predict), 0);
    check("reset_feat_ready", 32'(feat_ready), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: sum 10 > 5, ready exactly one edge after the 4th accept
    send_sample("t1", '{8'd1, 8'd1, 8'd1, 8'd1}, 0);
    @(negedge clk);
    check("t1_ready_in_cmp", 32'(ready), 0);
    @(negedge clk);
    check("t1_ready_latency", 32'(ready), 1);
    check("t1_predict", 32'(predict), 32'(2'b01));
    check("t1_model_res", m_res, 10);
    ack_pulse();

    // 2: strict compare, 10 > 10 is false
    thred = WW'(10);
    send_sample("t2", '{8'd1, 8'd1, 8'd1, 8'd1}, 0);
    wait_ready("t2");
    check("t2_predict", 32'(predict), 32'(2'b11));
    ack_pulse();

    // 3: extreme operands, no wrap
    set_w(-512, -512, -512, -512); bias = 10'h200; thred = WW'(511);
    send_sample("t3", '{8'h80, 8'h80, 8'h80, 8'h80}, 0);
    wait_ready("t3");
    check("t3_predict", 32'(predict), 32'(2'b01));
    check("t3_model_res", m_res, 262656);
    ack_pulse();

    // 4+5: gapped stream, extra beat refused in HOLD, ready held until ack
    set_w(1, 2, 3, 4); bias = '0; thred = WW'(5);
    send_sample("t4", '{8'd1, 8'd1, 8'd1, 8'd1}, 1);
    wait_ready("t4");
    check("t4_predict", 32'(predict), 32'(2'b01));
    @(posedge clk);
    #1 feat_valid = 1'b1; feat_data = 8'd7;
    repeat (10) begin
      @(negedge clk);
      check("t5_hold_ready", 32'(ready), 1);
      check("t5_hold_feat_ready", 32'(feat_ready), 0);
    end
    @(posedge clk);
    #1 feat_valid = 1'b0;
    ack_pulse();
    @(negedge clk);
    check("t5_ready_after_ack", 32'(ready), 0);
    check("t5_predict_after_ack", 32'(predict), 32'(2'b01));
    check("t5_feat_ready_after_ack", 32'(feat_ready), 1);

    // 6: reset mid-sample discards the partial sum
    thred = WW'(9);
    beat("t6", 8'd50);
    beat("t6", 8'd50);
    feat_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_ready", 32'(ready), 0);
    check("t6_rst_predict", 32'(predict), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send_sample("t6b", '{8'd1, 8'd1, 8'd1, 8'd1}, 0);
    wait_ready("t6b");
    check("t6_predict_clean", 32'(predict), 32'(2'b01));
    ack_pulse();

    // Randomized traffic: random gaps, random ack (also outside HOLD), new
    // coefficients only between samples.
    for (int c = 0; c < 2000; c++) begin
      if (q.size() == 0 && !m_pending && !m_hold && ($urandom % 6 == 0)) begin
        for (int i = 0; i < NFEAT; i++) weights[i*WW +: WW] = WW'($urandom);
        bias  = WW'($urandom);
        thred = WW'($urandom);
      end
      feat_valid = ($urandom % 3) != 0;
      feat_data  = FW'($urandom);
      ack        = ($urandom % 4) == 0;
      @(posedge clk);
      #1;
    end
    feat_valid = 1'b0;
    ack        = 1'b0;
    check("random_samples_done", 32'(n_done >= 60), 1);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
